// File: rtl/drop_pkg.sv
// Shared types and glyph constants for the drop sequencer and its display decoder.
package drop_pkg;

  typedef enum logic [1:0] {
    ST_COLD = 2'd0,
    ST_HOT  = 2'd1,
    ST_DROP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef logic [6:0] glyph_t;

  // Seven-segment glyphs, bit order gfedcba, active-high.
  localparam glyph_t GLYPH_C     = 7'b0111001;
  localparam glyph_t GLYPH_O     = 7'b1011100;
  localparam glyph_t GLYPH_L     = 7'b0111000;
  localparam glyph_t GLYPH_D     = 7'b1011110;
  localparam glyph_t GLYPH_H     = 7'b1110110;
  localparam glyph_t GLYPH_T     = 7'b1111000;
  localparam glyph_t GLYPH_R     = 7'b1010000;
  localparam glyph_t GLYPH_P     = 7'b1110011;
  localparam glyph_t GLYPH_N     = 7'b1010100;
  localparam glyph_t GLYPH_E     = 7'b1111001;
  localparam glyph_t GLYPH_SPACE = 7'b0000000;

  // Four glyphs, leftmost digit in g1.
  typedef struct packed {
    glyph_t g1;
    glyph_t g2;
    glyph_t g3;
    glyph_t g4;
  } glyph_word_t;

  function automatic glyph_word_t make_word(glyph_t a, glyph_t b, glyph_t c, glyph_t d);
    glyph_word_t w;
    w.g1 = a;
    w.g2 = b;
    w.g3 = c;
    w.g4 = d;
    return w;
  endfunction

endpackage

// File: rtl/drop_glyph_decode.sv
// Combinational map from sequencer state to the four-digit status text.
module drop_glyph_decode
  import drop_pkg::*;
(
  input  logic [1:0] state_code,
  output logic [6:0] seg1,
  output logic [6:0] seg2,
  output logic [6:0] seg3,
  output logic [6:0] seg4
);

  glyph_word_t word;

  // Select the status text for the current state; "COLd" is the safe fallback.
  always_comb begin
    word = make_word(GLYPH_C, GLYPH_O, GLYPH_L, GLYPH_D);
    case (state_t'(state_code))
      ST_COLD: word = make_word(GLYPH_C, GLYPH_O, GLYPH_L, GLYPH_D);
      ST_HOT:  word = make_word(GLYPH_SPACE, GLYPH_H, GLYPH_O, GLYPH_T);
      ST_DROP: word = make_word(GLYPH_D, GLYPH_R, GLYPH_O, GLYPH_P);
      ST_DONE: word = make_word(GLYPH_D, GLYPH_O, GLYPH_N, GLYPH_E);
      default: word = make_word(GLYPH_C, GLYPH_O, GLYPH_L, GLYPH_D);
    endcase
  end

  assign seg1 = word.g1;
  assign seg2 = word.g2;
  assign seg3 = word.g3;
  assign seg4 = word.g4;

endmodule

// File: rtl/drop_sequencer.sv
// Drop sequencer: confirms N below-limit samples, fires a timed drop pulse,
// then holds off until the measurement rises a hysteresis margin above the limit.
module drop_sequencer
  import drop_pkg::*;
#(
  parameter int INT_W           = 8,
  parameter int FRAC_W          = 8,
  parameter int CONFIRM_SAMPLES = 3,
  parameter int DROP_CYCLES     = 4,
  parameter int HYST            = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [INT_W+FRAC_W-1:0]   t_act,
  input  logic [INT_W+FRAC_W-1:0]   t_lim,
  input  logic                      sample_valid,
  input  logic                      drop_en,
  output logic                      drop_activated,
  output logic [6:0]                seven_seg1,
  output logic [6:0]                seven_seg2,
  output logic [6:0]                seven_seg3,
  output logic [6:0]                seven_seg4,
  output logic                      busy
);

  localparam int W  = INT_W + FRAC_W;
  localparam int CW = $clog2(CONFIRM_SAMPLES + 1);
  localparam int DW = $clog2(DROP_CYCLES + 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] confirm_cnt_reg, confirm_cnt_next;
  logic [DW-1:0] drop_cnt_reg, drop_cnt_next;

  logic          qualify;
  logic          rearm;
  logic [W:0]    lim_plus_hyst;
  logic [CW-1:0] confirm_inc;

  // Unsigned full-word compares; the re-arm threshold carries one extra bit so
  // a limit near full scale never wraps into a spurious re-arm.
  assign qualify       = t_act < t_lim;
  assign lim_plus_hyst = {1'b0, t_lim} + (W+1)'(HYST);
  assign rearm         = {1'b0, t_act} >= lim_plus_hyst;
  assign confirm_inc   = confirm_cnt_reg + 1'b1;

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_COLD;
      confirm_cnt_reg <= '0;
      drop_cnt_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      confirm_cnt_reg <= confirm_cnt_next;
      drop_cnt_reg    <= drop_cnt_next;
    end
  end

  // Next-state and counter logic; a low enable forces COLD from any state.
  always_comb begin
    state_next       = state_reg;
    confirm_cnt_next = confirm_cnt_reg;
    drop_cnt_next    = drop_cnt_reg;
    if (!drop_en) begin
      state_next       = ST_COLD;
      confirm_cnt_next = '0;
      drop_cnt_next    = '0;
    end else begin
      case (state_reg)
        ST_COLD: state_next = ST_HOT;
        ST_HOT: begin
          if (sample_valid) begin
            if (qualify) begin
              if (confirm_inc == CW'(CONFIRM_SAMPLES)) begin
                state_next       = ST_DROP;
                confirm_cnt_next = '0;
                drop_cnt_next    = '0;
              end else begin
                confirm_cnt_next = confirm_inc;
              end
            end else begin
              confirm_cnt_next = '0;
            end
          end
        end
        ST_DROP: begin
          if (drop_cnt_reg == DW'(DROP_CYCLES - 1)) begin
            state_next    = ST_DONE;
            drop_cnt_next = '0;
          end else begin
            drop_cnt_next = drop_cnt_reg + 1'b1;
          end
        end
        ST_DONE: begin
          if (sample_valid && rearm) begin
            state_next       = ST_HOT;
            confirm_cnt_next = '0;
          end
        end
        default: begin
          state_next       = ST_COLD;
          confirm_cnt_next = '0;
          drop_cnt_next    = '0;
        end
      endcase
    end
  end

  assign drop_activated = (state_reg == ST_DROP);
  assign busy           = (state_reg == ST_DROP);

  drop_glyph_decode u_glyph (
    .state_code (state_reg),
    .seg1       (seven_seg1),
    .seg2       (seven_seg2),
    .seg3       (seven_seg3),
    .seg4       (seven_seg4)
  );

endmodule

// File: tb/tb_drop_sequencer.sv
// Bench for drop_sequencer: directed vector table, reset corner sequences,
// and randomized traffic against a behavioural model.
module tb_drop_sequencer;

  localparam int CONF = 3;
  localparam int DCYC = 4;
  localparam int HYSTV = 256;
  localparam logic [15:0] LIM = 16'h2800;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] t_act = '0;
  logic [15:0] t_lim = LIM;
  logic        sample_valid = 1'b0;
  logic        drop_en = 1'b0;
  logic        drop_activated;
  logic [6:0]  seven_seg1, seven_seg2, seven_seg3, seven_seg4;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  drop_sequencer #(
    .INT_W(8), .FRAC_W(8), .CONFIRM_SAMPLES(CONF), .DROP_CYCLES(DCYC), .HYST(HYSTV)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .t_act          (t_act),
    .t_lim          (t_lim),
    .sample_valid   (sample_valid),
    .drop_en        (drop_en),
    .drop_activated (drop_activated),
    .seven_seg1     (seven_seg1),
    .seven_seg2     (seven_seg2),
    .seven_seg3     (seven_seg3),
    .seven_seg4     (seven_seg4),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        en;
    logic        sv;
    logic [15:0] ta;
    logic [15:0] tl;
    logic        exp_drop;
    logic [31:0] exp_txt;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [6:0] glyph_of(logic [7:0] c);
    case (c)
      "C": return 7'b0111001;
      "O": return 7'b1011100;
      "L": return 7'b0111000;
      "d": return 7'b1011110;
      "H": return 7'b1110110;
      "t": return 7'b1111000;
      "r": return 7'b1010000;
      "P": return 7'b1110011;
      "n": return 7'b1010100;
      "E": return 7'b1111001;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [27:0] text_glyphs(logic [31:0] t);
    return {glyph_of(t[31:24]), glyph_of(t[23:16]), glyph_of(t[15:8]), glyph_of(t[7:0])};
  endfunction

  function automatic vec_t mk(logic en, logic sv, logic [15:0] ta, logic [15:0] tl,
                              logic exp_drop, logic [31:0] exp_txt);
    vec_t v;
    v.en = en; v.sv = sv; v.ta = ta; v.tl = tl; v.exp_drop = exp_drop; v.exp_txt = exp_txt;
    return v;
  endfunction

  // Compare all outputs against the expected text and drop level.
  task automatic check(string name, logic [31:0] txt, logic exp_drop);
    logic [27:0] act_g, exp_g;
    act_g = {seven_seg1, seven_seg2, seven_seg3, seven_seg4};
    exp_g = text_glyphs(txt);
    vectors++;
    if (act_g !== exp_g || drop_activated !== exp_drop || busy !== exp_drop) begin
      miscompares++;
      $display("FAIL %s: got drop=%0b busy=%0b seg=%h, expected drop=%0b busy=%0b seg=%h (\"%s\")",
               name, drop_activated, busy, act_g, exp_drop, exp_drop, exp_g, txt);
    end else begin
      $display("ok   %s: drop=%0b text=\"%s\"", name, drop_activated, txt);
    end
  endtask

  // Drive one cycle of inputs, clock, and let outputs settle past the edge.
  task automatic drive(logic en, logic sv, logic [15:0] ta, logic [15:0] tl);
    drop_en = en; sample_valid = sv; t_act = ta; t_lim = tl;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: a named mode, a run length of qualifying samples,
  // and the number of pulse cycles still owed.
  string m_mode;
  int    m_run;
  int    m_left;

  function automatic void model_reset();
    m_mode = "COLD"; m_run = 0; m_left = 0;
  endfunction

  function automatic void model_edge(logic en, logic sv, int ta, int tl);
    if (!en) begin
      m_mode = "COLD"; m_run = 0; m_left = 0;
    end else if (m_mode == "COLD") begin
      m_mode = "HOT";
    end else if (m_mode == "HOT") begin
      if (sv) begin
        if (ta < tl) begin
          m_run++;
          if (m_run == CONF) begin
            m_mode = "DROP"; m_left = DCYC; m_run = 0;
          end
        end else begin
          m_run = 0;
        end
      end
    end else if (m_mode == "DROP") begin
      m_left--;
      if (m_left == 0) m_mode = "DONE";
    end else begin
      if (sv && ta >= tl + HYSTV) begin
        m_mode = "HOT"; m_run = 0;
      end
    end
  endfunction

  function automatic logic [31:0] model_txt();
    if (m_mode == "HOT")  return " HOt";
    if (m_mode == "DROP") return "drOP";
    if (m_mode == "DONE") return "dOnE";
    return "COLd";
  endfunction

  initial begin
    // Directed table: inputs driven for one cycle, expected outputs after the edge.
    vecs.push_back(mk(0, 1, 16'h1000, LIM, 0, "COLd"));
    vecs.push_back(mk(0, 1, 16'h1000, LIM, 0, "COLd"));
    vecs.push_back(mk(1, 0, 16'h3000, LIM, 0, " HOt"));
    vecs.push_back(mk(1, 1, 16'h3000, LIM, 0, " HOt"));
    vecs.push_back(mk(1, 1, 16'h27FF, LIM, 0, " HOt"));
    vecs.push_back(mk(1, 1, 16'h27FF, LIM, 0, " HOt"));
    vecs.push_back(mk(1, 1, 16'h27FF, LIM, 1, "drOP"));
    vecs.push_back(mk(1, 0, 16'h27FF, LIM, 1, "drOP"));
    vecs.push_back(mk(1, 1, 16'h3000, LIM, 1, "drOP"));
    vecs.push_back(mk(1, 0, 16'h27FF, LIM, 1, "drOP"));
    vecs.push_back(mk(1, 0, 16'h27FF, LIM, 0, "dOnE"));
    vecs.push_back(mk(1, 1, 16'h28FF, LIM, 0, "dOnE"));
    vecs.push_back(mk(1, 1, 16'h2900, LIM, 0, " HOt"));
    vecs.push_back(mk(1, 1, 16'h27FF, LIM, 0, " HOt"));
    vecs.push_back(mk(1, 1, 16'h27FF, LIM, 0, " HOt"));
    vecs.push_back(mk(1, 1, 16'h2800, LIM, 0, " HOt"));
    vecs.push_back(mk(1, 1, 16'h27FF, LIM, 0, " HOt"));
    vecs.push_back(mk(1, 0, 16'h27FF, LIM, 0, " HOt"));
    vecs.push_back(mk(1, 1, 16'h27FF, LIM, 0, " HOt"));
    vecs.push_back(mk(1, 1, 16'h27FF, LIM, 1, "drOP"));
    vecs.push_back(mk(1, 0, 16'h27FF, LIM, 1, "drOP"));
    vecs.push_back(mk(0, 0, 16'h27FF, LIM, 0, "COLd"));
    vecs.push_back(mk(1, 0, 16'h27FF, LIM, 0, " HOt"));
    vecs.push_back(mk(1, 1, 16'h27FF, LIM, 0, " HOt"));
    vecs.push_back(mk(1, 1, 16'h27FF, LIM, 0, " HOt"));
    vecs.push_back(mk(1, 1, 16'h27FF, LIM, 1, "drOP"));
    vecs.push_back(mk(1, 0, 16'h0000, LIM, 1, "drOP"));
    vecs.push_back(mk(1, 0, 16'h0000, LIM, 1, "drOP"));
    vecs.push_back(mk(1, 0, 16'h0000, LIM, 1, "drOP"));
    vecs.push_back(mk(1, 0, 16'h0000, LIM, 0, "dOnE"));
    vecs.push_back(mk(1, 1, 16'hFFFF, 16'hFF80, 0, "dOnE"));
    vecs.push_back(mk(1, 1, 16'hFFFF, LIM, 0, " HOt"));

    // Reset state.
    #2;
    check("reset_async", "COLd", 1'b0);
    @(posedge clk); #1;
    check("reset_held", "COLd", 1'b0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].sv, vecs[i].ta, vecs[i].tl);
      check($sformatf("vec%0d", i), vecs[i].exp_txt, vecs[i].exp_drop);
    end

    // Reset pulse mid-HOT after two qualifying samples.
    drive(0, 0, 16'h0000, LIM);
    drive(1, 0, 16'h0000, LIM);
    drive(1, 1, 16'h27FF, LIM);
    drive(1, 1, 16'h27FF, LIM);
    check("pre_rst_hot", " HOt", 1'b0);
    #2 rst = 1'b1;
    #1 check("rst_mid_hot", "COLd", 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1, 0, 16'h0000, LIM);
    check("rst_rel_hot", " HOt", 1'b0);
    drive(1, 1, 16'h27FF, LIM);
    check("rst_one_sample", " HOt", 1'b0);
    drive(1, 1, 16'h27FF, LIM);
    check("rst_two_sample", " HOt", 1'b0);
    drive(1, 1, 16'h27FF, LIM);
    check("rst_three_drop", "drOP", 1'b1);
    // Reset during the pulse drops the actuator without waiting for a clock.
    #2 rst = 1'b1;
    #1 check("rst_mid_drop", "COLd", 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Randomized traffic against the model, starting from a fresh reset.
    model_reset();
    for (int n = 0; n < 600; n++) begin
      logic        en, sv;
      int          tl, ta;
      case ($urandom_range(0, 3))
        0: tl = 'h2800;
        1: tl = 'hFF80;
        2: tl = 'h0040;
        default: tl = int'($urandom_range(0, 65535));
      endcase
      case ($urandom_range(0, 4))
        0: ta = tl - 1;
        1: ta = tl;
        2: ta = tl + HYSTV - 1 + int'($urandom_range(0, 2));
        3: ta = tl - int'($urandom_range(1, 300));
        default: ta = int'($urandom_range(0, 65535));
      endcase
      if (ta < 0) ta = 0;
      if (ta > 65535) ta = 65535;
      en = ($urandom_range(0, 24) != 0);
      sv = ($urandom_range(0, 2) != 0);
      drive(en, sv, 16'(ta), 16'(tl));
      model_edge(en, sv, ta, tl);
      check($sformatf("rnd%0d en=%0b sv=%0b ta=%h tl=%h", n, en, sv, ta[15:0], tl[15:0]),
            model_txt(), (m_mode == "DROP"));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
